regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback requesters (A: ALU, B: load unit).
//  Round-robin arbitrates valid/ready requests and decodes the granted rd into a one-hot write-enable vector.
//  Registers the decoded enable, index and data for the register-file write port.
//  Sits between the writeback sources and the register file; one write per cycle, x0 never written.
// PARAMETERS
//  REG_AW   5   register index width
//  NREGS    32  number of registers = width of wr_en (must equal 2**REG_AW)
//  DATA_W   32  register data width
// PORTS
//  clk      in   1        clock, all state updates on rising edge
//  rst      in   1        synchronous reset, active-high
//  hold     in   1        pipeline stall: blocks all grants this cycle
//  a_valid  in   1        requester A has a write pending
//  a_ready  out  1        A accepted this cycle (combinational)
//  a_rd     in   REG_AW   A destination register
//  a_data   in   DATA_W   A write data
//  b_valid  in   1        requester B has a write pending
//  b_ready  out  1        B accepted this cycle (combinational)
//  b_rd     in   REG_AW   B destination register
//  b_data   in   DATA_W   B write data
//  wr_en    out  NREGS    registered one-hot write enable to register file
//  wr_rd    out  REG_AW   registered index of current write
//  wr_data  out  DATA_W   registered data of current write
// BEHAVIOUR
//  - State: prio (1 bit, 0=A favoured, 1=B favoured), output stage (wr_en/wr_rd/wr_data).
//  - Reset: prio=0, wr_en=0, wr_rd=0, wr_data=0; a_ready=b_ready=0 while rst high.
//  - Grant (combinational, rst=0, hold=0): only A valid -> A; only B valid -> B;
//    both valid -> side selected by prio. At most one of a_ready/b_ready high per cycle.
//  - Accept = x_valid & x_ready. No grant when hold=1 or no valid; readies are 0.
//  - prio update on accept only: after A accepted prio=1; after B accepted prio=0. Unchanged otherwise.
//  - Latency: 1 cycle. Next edge after accept: wr_en = (rd==0) ? 0 : (1<<rd), wr_rd=rd, wr_data=data.
//  - No accept in a cycle -> next wr_en=0; wr_rd/wr_data hold previous values.
//  - rd=0: accepted normally (ready high, prio advances); wr_en all zero; wr_rd=0, wr_data=data.
//  - wr_en is one-hot or zero at all times; never more than one bit set.
//  - Same rd from A and B together: serialised in grant order; later-granted write lands
//    one cycle later and is the surviving value.
//  - Output stage never back-pressured: register file consumes every wr_en pulse.
//  - Reset mid-operation: in-flight registered write dropped; outputs cleared at that edge.
//  - Requesters must hold valid/rd/data stable until ready; arbiter does not check this.
// CONFIGURATION
//  REGARB_FWD_EN defined: adds ports fwd_rs (in, REG_AW), fwd_hit (out, 1), fwd_data (out, DATA_W).
//    fwd_hit = (wr_en != 0) & (wr_rd == fwd_rs), combinational; fwd_data = wr_data.
//    fwd_rs=0 never hits. Lets decode read the write landing this cycle.
//  REGARB_FWD_EN undefined: ports absent, no compare logic; all other behaviour identical.
// TESTING
//  1. rst=1 two cycles, then idle -> wr_en=0, wr_rd=0, wr_data=0, a_ready=b_ready=0.
//  2. A only: a_rd=5, a_data=32'hDEADBEEF -> a_ready=1 same cycle; next cycle
//     wr_en=32'h0000_0020, wr_data=32'hDEADBEEF; following cycle wr_en=0.
//  3. A and B valid 4 cycles from reset, rd 3/7 -> grants A,B,A,B; wr_en alternates 32'h8/32'h80.
//  4. a_rd=0 -> a_ready=1, next wr_en=0, prio flips to B.
//  5. Both valid, hold=1 -> readies 0, wr_en=0 next cycle, prio unchanged; hold=0 -> A granted.
//  6. rst asserted cycle after accept of rd=9 -> wr_en=0 at that edge; with REGARB_FWD_EN
//     fwd_rs=9 during valid write -> fwd_hit=1, fwd_data=wr_data; fwd_rs=0 -> fwd_hit=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between the ALU (A) and load unit (B); registers a one-hot
//               write enable, index and data. x0 is never written.
//               Optional macro REGARB_FWD_EN adds a same-cycle forward port.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int REG_AW = 5,
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
`ifdef REGARB_FWD_EN
    input  logic [REG_AW-1:0] fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [NREGS-1:0]  wr_en,
    output logic [REG_AW-1:0] wr_rd,
    output logic [DATA_W-1:0] wr_data
);

    logic              r_prio;
    logic [NREGS-1:0]  r_wr_en;
    logic [REG_AW-1:0] r_wr_rd;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic [REG_AW-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREGS-1:0]  w_dec;

    // r_prio = 1 means B wins a tie; ready is itself the grant.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst && !hold) begin
            w_grant_a = a_valid && (!b_valid || !r_prio);
            w_grant_b = b_valid && (!a_valid ||  r_prio);
        end
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign w_accept   = w_grant_a | w_grant_b;
    assign w_sel_rd   = w_grant_b ? b_rd   : a_rd;
    assign w_sel_data = w_grant_b ? b_data : a_data;

    // Bit 0 is never set so x0 stays hard-wired to zero.
    always_comb begin
        w_dec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_dec[i] = (w_sel_rd == REG_AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_wr_en   <= '0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_grant_a) begin
                r_prio <= 1'b1;
            end else if (w_grant_b) begin
                r_prio <= 1'b0;
            end
            r_wr_en <= w_accept ? w_dec : '0;
            if (w_accept) begin
                r_wr_rd   <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_rd   = r_wr_rd;
    assign wr_data = r_wr_data;

`ifdef REGARB_FWD_EN
    // wr_en is zero for x0 writes, so fwd_rs == 0 can never hit.
    assign fwd_hit  = (|r_wr_en) && (r_wr_rd == fwd_rs) && (fwd_rs != '0);
    assign fwd_data = r_wr_data;
`endif

endmodule
`default_nettype wire
